andgate_arbiter: RTL and testbench
==================================

ANDGATE_ARBITER -- requirements
Module: andgate_arbiter

Interface
REQ-001 The module SHALL have parameter Port_Num, default 4, giving the number of requesters (legal range 1..16).
REQ-002 The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous reset, active high.
REQ-006 req_valid  input  Port_Num  per-requester operand-pair valid.
REQ-007 req_a  input  Port_Num*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  Port_Num*WIDTH  operand B; same packing as req_a.
REQ-009 req_ready  output  Port_Num  one-hot-or-zero grant; a transfer occurs on req_valid[i] & req_ready[i].
REQ-010 out_valid  output  1  result register holds a valid result.
REQ-011 out_data  output  WIDTH  registered result a & b.
REQ-012 out_id  output  ID_W  index of the granted requester; ID_W = max(1, clog2(Port_Num)).
REQ-013 out_ready  input  1  consumer accepts the result when out_valid & out_ready.

Function
REQ-014 The shared datapath SHALL compute out_data = req_a[g] & req_b[g] bitwise, where g is the granted index.
REQ-015 The output stage SHALL be a two-state machine, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 can_load SHALL equal (!out_valid) | out_ready.
REQ-017 Grants SHALL be issued only when can_load is 1; otherwise req_ready SHALL be all zero.
REQ-018 At most one req_ready bit SHALL be 1 per cycle, and only for a requester with req_valid=1; req_ready depends combinationally on req_valid, the pointer and can_load.
REQ-019 Arbitration SHALL be round-robin: the search starts at pointer ptr, ascending with wrap from Port_Num-1 to 0.
REQ-020 After a grant to index g, ptr SHALL become (g+1) mod Port_Num; without a grant, ptr SHALL hold.
REQ-021 Latency SHALL be one cycle: a transfer at edge N produces out_valid=1 with data and id after edge N.
REQ-022 Transitions: EMPTY->FULL on grant; FULL->EMPTY on out_ready with no grant; FULL->FULL on out_ready with a grant (new result loaded, throughput 1 per cycle); FULL holds when out_ready=0.
REQ-023 While FULL with out_ready=0, out_data and out_id SHALL remain stable.
REQ-024 A single active requester SHALL be granted regardless of ptr; when no requester is valid, no grant is issued.
REQ-025 When Port_Num=1, ptr SHALL stay 0 and out_id SHALL be 0.

Reset
REQ-026 On rst: out_valid=0, out_data=0, out_id=0, ptr=0 (requester 0 has highest priority), and req_ready=0 during the reset cycle.
REQ-027 Reset asserted while FULL SHALL discard the held result without handshake.

Configuration
REQ-028 With macro ANDGATE_ARB_STATS_EN defined, the module SHALL add output grant_cnt, 16 bits: it increments on every grant, saturates at 16'hFFFF, and clears on rst.
REQ-029 Without ANDGATE_ARB_STATS_EN, grant_cnt and its logic SHALL be absent.

Structure
REQ-030 Package andgate_pkg SHALL hold the clog2 function, the ID_W derivation and the output-state encoding (EMPTY=1'b0, FULL=1'b1).
REQ-031 The round-robin picker SHALL be sub-module andgate_rr_pick: inputs req vector and ptr; outputs grant one-hot and grant index; purely combinational.

Verification
REQ-032 Reset then single request: Port_Num=4, WIDTH=8, req_valid=0001, a=8'hF0, b=8'h3C, out_ready=1 -> req_ready=0001; the next cycle gives out_valid=1, out_data=8'h30, out_id=0.
REQ-033 Fairness: req_valid=1111 held, out_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one result per cycle.
REQ-034 Backpressure: FULL with out_id=2, out_ready=0 for 3 cycles, req_valid=1111 -> req_ready=0000 and out_data/out_id stable; out_ready=1 -> grant to 3 in the same cycle.
REQ-035 Wrap and skip: ptr=3, req_valid=0110 -> grant 1, then ptr=2.
REQ-036 Reset mid-operation: FULL, rst=1 for 1 cycle -> out_valid=0, ptr=0; then req_valid=1001 -> grant 0.
REQ-037 With ANDGATE_ARB_STATS_EN: 5 grants -> grant_cnt=5; preload near saturation -> grant_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/andgate_pkg.sv
// Shared definitions for the AND-gate arbiter: width helpers and output-stage state encoding.
package andgate_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int k = 0; k < 32; k++) begin
         if ((1 << r) < n) r++;
      end
      return r;
   endfunction

   // An index field is always at least one bit wide, even for a single requester.
   function automatic int id_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/andgate_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to index 0.
module andgate_rr_pick
   import andgate_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_idx,
   output logic           grant_any
);

   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (!grant_any && req[idx]) begin
            grant_any      = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/andgate_arbiter.sv
// Round-robin arbiter feeding a shared a&b datapath into a one-entry output register.
// Optional grant counter enabled by defining ANDGATE_ARB_STATS_EN.
module andgate_arbiter
   import andgate_pkg::*;
#(
   parameter int  Port_Num = 4,
   parameter int  WIDTH    = 8,
   localparam int ID_W     = id_w(Port_Num)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [Port_Num-1:0]       req_valid,
   input  logic [Port_Num*WIDTH-1:0] req_a,
   input  logic [Port_Num*WIDTH-1:0] req_b,
   output logic [Port_Num-1:0]       req_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [ID_W-1:0]           out_id,
   input  logic                      out_ready
`ifdef ANDGATE_ARB_STATS_EN
   ,
   output logic [15:0]               grant_cnt
`endif
);

   out_state_e        state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;

   logic [Port_Num-1:0] pick_grant;
   logic [ID_W-1:0]     pick_idx;
   logic                pick_any;
   logic                can_load;
   logic                grant;

   logic [WIDTH-1:0] a_arr [Port_Num];
   logic [WIDTH-1:0] b_arr [Port_Num];

   genvar gi;
   generate
      for (gi = 0; gi < Port_Num; gi++) begin : g_unpack
         assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
         assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
      end
   endgenerate

   andgate_rr_pick #(
      .N   (Port_Num),
      .IDW (ID_W)
   ) u_pick (
      .req       (req_valid),
      .ptr       (ptr_q),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .grant_any (pick_any)
   );

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_id    = id_q;
   assign can_load  = !out_valid || out_ready;
   // Reset gates the grant so no transfer is acknowledged in the reset cycle.
   assign grant     = can_load && pick_any && !rst;
   assign req_ready = grant ? pick_grant : '0;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      if (grant) begin
         ptr_d = (pick_idx == ID_W'(Port_Num - 1)) ? '0 : pick_idx + ID_W'(1);
      end
      case (state_q)
         EMPTY: begin
            if (grant) begin
               state_d = FULL;
               data_d  = a_arr[pick_idx] & b_arr[pick_idx];
               id_d    = pick_idx;
            end
         end
         FULL: begin
            if (out_ready) begin
               if (grant) begin
                  data_d = a_arr[pick_idx] & b_arr[pick_idx];
                  id_d   = pick_idx;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ANDGATE_ARB_STATS_EN
   logic [15:0] grant_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
      end else if (grant && (grant_cnt_q != 16'hFFFF)) begin
         grant_cnt_q <= grant_cnt_q + 16'd1;
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_andgate_arbiter.sv
// Scoreboard bench for andgate_arbiter: directed scenarios followed by random traffic,
// checked against a queue-based round-robin reference model.
module tb_andgate_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [1:0]     out_id;
   logic           out_ready;
`ifdef ANDGATE_ARB_STATS_EN
   logic [15:0]    grant_cnt;
`endif

   int checks = 0;
   int errors = 0;
   bit quiet  = 1'b0;

   andgate_arbiter #(.Port_Num(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready)
`ifdef ANDGATE_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending results queue, pointer, occupancy and grant count.
   typedef struct {
      logic [W-1:0] d;
      int           id;
   } exp_t;

   exp_t sb[$];
   int   m_ptr  = 0;
   bit   m_full = 1'b0;
   int   m_cnt  = 0;

   function automatic int rr_winner(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic int model_grant();
      int g;
      g = rr_winner(req_valid, m_ptr);
      if (rst || (m_full && !out_ready)) return -1;
      return g;
   endfunction

   always @(posedge clk) begin
      int   g;
      exp_t e;
      g = model_grant();
      if (rst) begin
         m_ptr  = 0;
         m_full = 1'b0;
         m_cnt  = 0;
         sb.delete();
      end else begin
         if (m_full && out_ready && g < 0) m_full = 1'b0;
         if (g >= 0) begin
            e.d    = req_a[g*W +: W] & req_b[g*W +: W];
            e.id   = g;
            sb.push_back(e);
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
            if (m_cnt < 65535) m_cnt++;
         end
      end
   end

   // Monitor: grant vector, occupancy and the displayed result, sampled mid-cycle.
   always @(negedge clk) begin
      int         g;
      logic [3:0] exp_rdy;
      exp_t       e;
      g       = model_grant();
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_full));
`ifdef ANDGATE_ARB_STATS_EN
      chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`endif
      if (out_valid) begin
         if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
         end else begin
            e = sb[0];
            chk("out_data", 32'(out_data), 32'(e.d));
            chk("out_id", 32'(out_id), 32'(e.id));
            if (out_ready) begin
               void'(sb.pop_front());
               if (!quiet) $display("xfer id=%0d data=%h", out_id, out_data);
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] v, input logic ordy);
      req_valid = v;
      out_ready = ordy;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = W'($urandom);
         req_b[i*W +: W] = W'($urandom);
      end
   endtask

   task automatic do_reset(input int n = 2);
      rst = 1'b1;
      step(n);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drive(4'b0000, 1'b1);
      do_reset(2);

      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_out_id", 32'(out_id), 32'd0);

      // Single request with known operands.
      drive(4'b0001, 1'b1);
      req_a[0 +: W] = 8'hF0;
      req_b[0 +: W] = 8'h3C;
      #1;
      chk("single_req_ready", 32'(req_ready), 32'h1);
      step();
      drive(4'b0000, 1'b1);
      chk("single_out_valid", 32'(out_valid), 32'd1);
      chk("single_out_data", 32'(out_data), 32'h30);
      chk("single_out_id", 32'(out_id), 32'd0);
      step();

      // Fairness: all requesting, 0..3 twice.
      do_reset(1);
      for (int c = 0; c < 8; c++) begin
         drive(4'b1111, 1'b1);
         #1;
         chk("fair_grant", 32'(req_ready), 32'(1 << (c % 4)));
         step();
      end

      // Backpressure with id 2 held, then release grants 3.
      drive(4'b0100, 1'b1);
      step();
      for (int c = 0; c < 3; c++) begin
         drive(4'b1111, 1'b0);
         #1;
         chk("bp_ready_zero", 32'(req_ready), 32'd0);
         chk("bp_id_hold", 32'(out_id), 32'd2);
         step();
      end
      drive(4'b1111, 1'b1);
      #1;
      chk("bp_release_grant", 32'(req_ready), 32'h8);
      step();

      // Wrap and skip: drive ptr to 3, then 0110 wins at 1.
      drive(4'b0100, 1'b1);
      step();
      drive(4'b0110, 1'b1);
      #1;
      chk("wrap_grant1", 32'(req_ready), 32'h2);
      step();
      drive(4'b0110, 1'b1);
      #1;
      chk("wrap_then_2", 32'(req_ready), 32'h4);
      step();

      // Reset while FULL, then 1001 wins at 0.
      drive(4'b0000, 1'b0);
      chk("pre_rst_full", 32'(out_valid), 32'd1);
      do_reset(1);
      chk("mid_rst_empty", 32'(out_valid), 32'd0);
      drive(4'b1001, 1'b1);
      #1;
      chk("post_rst_grant0", 32'(req_ready), 32'h1);
      step();

      // Random traffic with occasional reset.
      for (int c = 0; c < 400; c++) begin
         drive(4'($urandom), ($urandom_range(0, 3) != 0));
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      drive(4'b0000, 1'b1);
      step(3);

`ifdef ANDGATE_ARB_STATS_EN
      do_reset(1);
      for (int c = 0; c < 5; c++) begin
         drive(4'b1111, 1'b1);
         step();
      end
      drive(4'b0000, 1'b1);
      step();
      chk("stats_five", 32'(grant_cnt), 32'd5);
      quiet = 1'b1;
      drive(4'b1111, 1'b1);
      step(65540);
      drive(4'b0000, 1'b1);
      step(2);
      quiet = 1'b0;
      chk("stats_saturate", 32'(grant_cnt), 32'hFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
